// File: rtl/gated_capture_bank.sv
// Multi-channel gated capture register with per-channel preset, global gate enable and
// optional shadow stage so that one COMMIT updates every pending channel in the same edge.
module gated_capture_bank #(
  parameter int              WIDTH    = 8,
  parameter int              CHANNELS = 4,
  parameter logic [WIDTH-1:0] INIT    = WIDTH'(8'hFF),
  parameter bit              DIRECT   = 1'b0
) (
  input  logic                        C,
  input  logic                        CLR_N,
  input  logic [CHANNELS*WIDTH-1:0]   D,
  input  logic [CHANNELS-1:0]         G,
  input  logic                        GE,
  input  logic [CHANNELS-1:0]         PRE,
  input  logic                        COMMIT,
  output logic [CHANNELS*WIDTH-1:0]   Q,
  output logic [CHANNELS-1:0]         DIRTY,
  output logic                        COMMIT_ACK
);

  // COMMIT is a single-cycle request with no back-pressure; COMMIT_ACK is its registered
  // echo one cycle later, independent of whether any channel was pending.

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    logic             load;
    logic [WIDTH-1:0] d_k;
    logic [WIDTH-1:0] q_r;

    assign load = G[k] & GE;
    assign d_k  = D[k*WIDTH +: WIDTH];
    assign Q[k*WIDTH +: WIDTH] = q_r;

    if (DIRECT) begin : g_direct
      always_ff @(posedge C or negedge CLR_N) begin
        if (!CLR_N) begin
          q_r <= INIT;
        end else if (PRE[k]) begin
          q_r <= INIT;
        end else if (load) begin
          q_r <= d_k;
        end
      end

      assign DIRTY[k] = 1'b0;
    end else begin : g_shadow
      logic [WIDTH-1:0] shadow_r;
      logic             dirty_r;

      // Preset beats load beats commit; a load coinciding with COMMIT writes straight through.
      always_ff @(posedge C or negedge CLR_N) begin
        if (!CLR_N) begin
          shadow_r <= INIT;
          q_r      <= INIT;
          dirty_r  <= 1'b0;
        end else if (PRE[k]) begin
          shadow_r <= INIT;
          q_r      <= INIT;
          dirty_r  <= 1'b0;
        end else if (load && COMMIT) begin
          shadow_r <= d_k;
          q_r      <= d_k;
          dirty_r  <= 1'b0;
        end else if (load) begin
          shadow_r <= d_k;
          dirty_r  <= 1'b1;
        end else if (COMMIT && dirty_r) begin
          q_r     <= shadow_r;
          dirty_r <= 1'b0;
        end
      end

      assign DIRTY[k] = dirty_r;
    end
  end

  if (DIRECT) begin : g_ack_off
    assign COMMIT_ACK = 1'b0;
  end else begin : g_ack_on
    logic ack_r;

    always_ff @(posedge C or negedge CLR_N) begin
      if (!CLR_N) begin
        ack_r <= 1'b0;
      end else begin
        ack_r <= COMMIT;
      end
    end

    assign COMMIT_ACK = ack_r;
  end

endmodule

// File: tb/tb_gated_capture_bank.sv
// Bench for gated_capture_bank: shadowed and direct instances share stimulus; a reference
// model queues expected outputs per driven cycle, popped and compared after each edge.
module tb_gated_capture_bank;

  logic        clk;
  logic        rst_n;
  logic [31:0] d;
  logic [3:0]  g;
  logic        ge;
  logic [3:0]  pre;
  logic        commit;
  logic [31:0] q0, q1;
  logic [3:0]  dirty0, dirty1;
  logic        ack0, ack1;

  int checks   = 0;
  int failures = 0;

  // expected {q0, dirty0, ack0, q1}
  logic [68:0] exp_q[$];

  logic [3:0][7:0] m_sh;
  logic [3:0][7:0] m_q0;
  logic [3:0][7:0] m_q1;
  logic [3:0]      m_dirty;
  logic            m_ack;

  gated_capture_bank #(.WIDTH(8), .CHANNELS(4), .INIT(8'hFF), .DIRECT(1'b0)) dut0 (
    .C(clk), .CLR_N(rst_n), .D(d), .G(g), .GE(ge), .PRE(pre), .COMMIT(commit),
    .Q(q0), .DIRTY(dirty0), .COMMIT_ACK(ack0)
  );

  gated_capture_bank #(.WIDTH(8), .CHANNELS(4), .INIT(8'hFF), .DIRECT(1'b1)) dut1 (
    .C(clk), .CLR_N(rst_n), .D(d), .G(g), .GE(ge), .PRE(pre), .COMMIT(commit),
    .Q(q1), .DIRTY(dirty1), .COMMIT_ACK(ack1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sh    = {4{8'hFF}};
    m_q0    = {4{8'hFF}};
    m_q1    = {4{8'hFF}};
    m_dirty = '0;
    m_ack   = 1'b0;
  endtask

  task automatic model_step(input logic [31:0] d_i, input logic [3:0] g_i, input logic ge_i,
                            input logic [3:0] pre_i, input logic commit_i);
    for (int k = 0; k < 4; k++) begin
      logic ld;
      ld = g_i[k] && ge_i;
      if (pre_i[k]) begin
        m_sh[k] = 8'hFF; m_q0[k] = 8'hFF; m_dirty[k] = 1'b0;
      end else if (ld && commit_i) begin
        m_sh[k] = d_i[k*8 +: 8]; m_q0[k] = d_i[k*8 +: 8]; m_dirty[k] = 1'b0;
      end else if (ld) begin
        m_sh[k] = d_i[k*8 +: 8]; m_dirty[k] = 1'b1;
      end else if (commit_i && m_dirty[k]) begin
        m_q0[k] = m_sh[k]; m_dirty[k] = 1'b0;
      end
      if (pre_i[k])  m_q1[k] = 8'hFF;
      else if (ld)   m_q1[k] = d_i[k*8 +: 8];
    end
    m_ack = commit_i;
  endtask

  // driver: one clock edge per call, expected outputs queued at drive time
  task automatic step(input logic [31:0] d_i, input logic [3:0] g_i, input logic ge_i,
                      input logic [3:0] pre_i, input logic commit_i);
    logic [68:0] e;
    @(negedge clk);
    d = d_i; g = g_i; ge = ge_i; pre = pre_i; commit = commit_i;
    model_step(d_i, g_i, ge_i, pre_i, commit_i);
    exp_q.push_back({m_q0, m_dirty, m_ack, m_q1});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("queue_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check("q0",     64'(q0),     64'(e[68:37]));
      check("dirty0", 64'(dirty0), 64'(e[36:33]));
      check("ack0",   64'(ack0),   64'(e[32]));
      check("q1",     64'(q1),     64'(e[31:0]));
      check("dirty1", 64'(dirty1), 64'd0);
      check("ack1",   64'(ack1),   64'd0);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check("rst_q0",     64'(q0),     64'hFFFF_FFFF);
    check("rst_dirty0", 64'(dirty0), 64'd0);
    check("rst_ack0",   64'(ack0),   64'd0);
    check("rst_q1",     64'(q1),     64'hFFFF_FFFF);
    model_reset();
    d = '0; g = '0; ge = 1'b0; pre = '0; commit = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    d = '0; g = '0; ge = 1'b0; pre = '0; commit = 1'b0;
    model_reset();
    #3;
    rst_n = 1'b1;

    // reset between edges
    pulse_reset();

    // staged load, then commit
    step(32'h4433_2211, 4'b0101, 1'b1, 4'b0000, 1'b0);
    check("stage_q0",    64'(q0),     64'hFFFF_FFFF);
    check("stage_dirty", 64'(dirty0), 64'h5);
    step(32'h0, 4'b0000, 1'b0, 4'b0000, 1'b1);
    check("commit_q0",  64'(q0),   64'hFF33_FF11);
    check("commit_ack", 64'(ack0), 64'd1);
    step(32'h0, 4'b0000, 1'b0, 4'b0000, 1'b0);
    check("ack_drop",   64'(ack0), 64'd0);

    // gate enable low blocks loads; commit still acknowledged
    step(32'h0, 4'b1111, 1'b0, 4'b0000, 1'b0);
    check("ge0_dirty", 64'(dirty0), 64'd0);
    step(32'h0, 4'b1111, 1'b0, 4'b0000, 1'b1);
    check("ge0_q0",  64'(q0),   64'hFF33_FF11);
    check("ge0_ack", 64'(ack0), 64'd1);

    // preset beats load and commit; write-through on ch1
    step(32'h0000_00AA, 4'b0001, 1'b1, 4'b0000, 1'b0);
    step(32'h0000_7755, 4'b0011, 1'b1, 4'b0001, 1'b1);
    check("simul_q0",    64'(q0),     64'hFF33_77FF);
    check("simul_dirty", 64'(dirty0), 64'd0);

    // reset discards a pending shadow
    step(32'h00C3_0000, 4'b0100, 1'b1, 4'b0000, 1'b0);
    check("pend_dirty", 64'(dirty0), 64'h4);
    pulse_reset();
    step(32'h0, 4'b0000, 1'b0, 4'b0000, 1'b1);
    check("post_rst_q0",    64'(q0),     64'hFFFF_FFFF);
    check("post_rst_dirty", 64'(dirty0), 64'd0);

    // direct instance loads on the next edge and ignores commit
    step(32'h0000_5A00, 4'b0010, 1'b1, 4'b0000, 1'b0);
    check("direct_q1", 64'(q1), 64'hFFFF_5AFF);
    step(32'h0, 4'b0000, 1'b0, 4'b0000, 1'b1);
    check("direct_hold", 64'(q1),   64'hFFFF_5AFF);
    check("direct_ack",  64'(ack1), 64'd0);

    // back-to-back commits
    step(32'h0, 4'b0000, 1'b0, 4'b0000, 1'b1);
    step(32'h0, 4'b0000, 1'b0, 4'b0000, 1'b1);
    check("b2b_ack", 64'(ack0), 64'd1);

    // random traffic
    for (int i = 0; i < 60; i++) begin
      step($urandom(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
           ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
           1'($urandom_range(0, 2) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
